// File: rtl/branch_compare_seq_if.sv
// Request/response bundle for the multi-cycle branch comparator.
// The master drives operands and out_ready; the slave returns the flags and the branch decision.
interface branch_compare_seq_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic             eq;
    logic             ne;
    logic             gt;
    logic             le;
    logic             lt;
    logic             ge;
    logic             taken;
    logic             illegal;
    logic             busy;

    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_valid, eq, ne, gt, le, lt, ge, taken, illegal, busy
    );

    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_valid, eq, ne, gt, le, lt, ge, taken, illegal, busy
    );
endinterface

// File: rtl/branch_compare_seq.sv
// Multi-cycle RISC-V branch comparator: walks the operands CHUNK bits per cycle from the MSB,
// optionally stopping at the first differing chunk, and reports relational flags plus taken.
module branch_compare_seq #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned CHUNK      = 8,
    parameter bit          EARLY_EXIT = 1'b1
) (
    input logic                  clk,
    input logic                  rst,
    branch_compare_seq_if.slave  cmp_io
);
    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    state_e             state_q;
    logic [WIDTH-1:0]   a_q, b_q;
    logic [2:0]         op_q;
    logic [IDX_W-1:0]   idx_q;
    logic               found_q, gt_acc_q;
    logic               eq_q, ne_q, gt_q, le_q, lt_q, ge_q;
    logic               taken_q, illegal_q, out_valid_q, busy_q;

    logic [CHUNK-1:0]   chunk_a, chunk_b;
    logic               chunk_diff, chunk_gt, finish, fin_gt, fin_lt;
    logic [WIDTH-1:0]   msb_flip;

    function automatic logic taken_of(input logic [2:0] op, input logic eq, input logic lt);
        logic t;
        t = 1'b0;
        case (op)
            3'b000:         t = eq;
            3'b001:         t = !eq;
            3'b100, 3'b110: t = lt;
            3'b101, 3'b111: t = !lt;
            default:        t = 1'b0;
        endcase
        return t;
    endfunction

    // Inverting both MSBs maps two's-complement order onto unsigned order.
    always_comb begin
        msb_flip            = '0;
        msb_flip[WIDTH-1]   = (cmp_io.op[2:1] == 2'b10);
    end

    // Current chunk compare and the result that would be latched if we stop now.
    always_comb begin
        chunk_a    = CHUNK'(a_q >> (32'(idx_q) * CHUNK));
        chunk_b    = CHUNK'(b_q >> (32'(idx_q) * CHUNK));
        chunk_diff = (chunk_a != chunk_b);
        chunk_gt   = (chunk_a > chunk_b);
        finish     = (idx_q == '0) || (EARLY_EXIT && chunk_diff);
        fin_gt     = found_q ? gt_acc_q  : (chunk_diff && chunk_gt);
        fin_lt     = found_q ? !gt_acc_q : (chunk_diff && !chunk_gt);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            idx_q       <= '0;
            found_q     <= 1'b0;
            gt_acc_q    <= 1'b0;
            eq_q        <= 1'b0;
            ne_q        <= 1'b0;
            gt_q        <= 1'b0;
            le_q        <= 1'b0;
            lt_q        <= 1'b0;
            ge_q        <= 1'b0;
            taken_q     <= 1'b0;
            illegal_q   <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmp_io.in_valid) begin
                        a_q      <= cmp_io.a ^ msb_flip;
                        b_q      <= cmp_io.b ^ msb_flip;
                        op_q     <= cmp_io.op;
                        idx_q    <= IDX_W'(NCHUNK - 1);
                        found_q  <= 1'b0;
                        gt_acc_q <= 1'b0;
                        busy_q   <= 1'b1;
                        state_q  <= BUSY;
                    end
                end
                BUSY: begin
                    if (finish) begin
                        eq_q      <= !fin_gt && !fin_lt;
                        ne_q      <= fin_gt || fin_lt;
                        gt_q      <= fin_gt;
                        le_q      <= !fin_gt;
                        lt_q      <= fin_lt;
                        ge_q      <= !fin_lt;
                        taken_q   <= taken_of(op_q, !(fin_gt || fin_lt), fin_lt);
                        illegal_q <= (op_q[2:1] == 2'b01);
                        idx_q     <= '0;
                        state_q   <= DONE;
                    end else begin
                        idx_q <= idx_q - IDX_W'(1);
                        // Only the most significant differing chunk decides the order.
                        if (chunk_diff && !found_q) begin
                            found_q  <= 1'b1;
                            gt_acc_q <= chunk_gt;
                        end
                    end
                end
                DONE: begin
                    if (!out_valid_q) begin
                        out_valid_q <= 1'b1;
                    end else if (cmp_io.out_ready) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // in_ready drops with rst itself so it is low for the whole reset pulse.
    assign cmp_io.in_ready  = (state_q == IDLE) && !rst;
    assign cmp_io.out_valid = out_valid_q;
    assign cmp_io.eq        = eq_q;
    assign cmp_io.ne        = ne_q;
    assign cmp_io.gt        = gt_q;
    assign cmp_io.le        = le_q;
    assign cmp_io.lt        = lt_q;
    assign cmp_io.ge        = ge_q;
    assign cmp_io.taken     = taken_q;
    assign cmp_io.illegal   = illegal_q;
    assign cmp_io.busy      = busy_q;
endmodule
